wb_stage: RTL and testbench

- Writeback stage directly upstream of the 32x32 register file; it drives the file's single write port.
- Merges two result sources: single-cycle ALU results (valid/ready, buffered in a small FIFO) and load responses from the data memory (valid only, never stalled).
- Performs RV32 load byte/halfword extraction with sign or zero extension.
- Registers the write-port signals.

---
 rtl/wb_stage.sv | 148 ++++++++++++++
 tb/tb_wb_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates load responses and buffered ALU results onto the
// register file's single write port, extracting RV32 load bytes/halfwords.
module wb_stage #(
    parameter int XLEN           = 32,
    parameter int ALU_FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_word,
    output logic            rf_w_en,
    output logic [4:0]      rf_write_rg,
    output logic [XLEN-1:0] rf_write_data,
    output logic            ld_err,
    output logic            busy,
    output logic [15:0]     wb_count
);

    localparam int PTR_W = $clog2(ALU_FIFO_DEPTH);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LOAD,
        SEL_FIFO,
        SEL_BYPASS
    } wr_sel_t;

    // NOTE: storage arrays carry no reset; the pointers alone define validity,
    // so clearing the entries would only cost reset routing.
    logic [4:0]      fifo_rd   [ALU_FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [ALU_FIFO_DEPTH];
    logic [PTR_W:0]  wr_ptr;
    logic [PTR_W:0]  rd_ptr;

    logic            fifo_empty;
    logic            fifo_full;
    logic            alu_fire;
    logic            push;
    logic            pop;
    wr_sel_t         sel;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [XLEN-1:0] ld_value;
    logic            ld_illegal;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign alu_ready = !rst && !fifo_full;
    assign alu_fire  = alu_valid && alu_ready;
    assign busy      = !fifo_empty;

    // RV32 load extraction; illegal funct3 yields zero data and flags an error.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // infer a latch.
        ld_value   = '0;
        ld_illegal = 1'b0;
        unique case (ld_funct3)
            3'b000, 3'b100: begin
                logic [7:0] b;
                unique case (ld_addr_lo)
                    2'd0:    b = ld_word[7:0];
                    2'd1:    b = ld_word[15:8];
                    2'd2:    b = ld_word[23:16];
                    default: b = ld_word[31:24];
                endcase
                ld_value = {{(XLEN-8){b[7] & ~ld_funct3[2]}}, b};
            end
            3'b001, 3'b101: begin
                logic [15:0] h;
                h = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
                ld_value = {{(XLEN-16){h[15] & ~ld_funct3[2]}}, h};
            end
            3'b010:  ld_value = ld_word;
            default: ld_illegal = 1'b1;
        endcase
    end

    // Strict priority: load, then FIFO head, then same-cycle ALU bypass.
    always_comb begin
        sel      = SEL_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (ld_valid) begin
            sel      = SEL_LOAD;
            sel_rd   = ld_rd;
            sel_data = ld_value;
        end else if (!fifo_empty) begin
            sel      = SEL_FIFO;
            sel_rd   = fifo_rd[rd_ptr[PTR_W-1:0]];
            sel_data = fifo_data[rd_ptr[PTR_W-1:0]];
        end else if (alu_fire) begin
            sel      = SEL_BYPASS;
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end
    end

    assign pop  = (sel == SEL_FIFO);
    assign push = alu_fire && (sel != SEL_BYPASS);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr[PTR_W-1:0]]   <= alu_rd;
            fifo_data[wr_ptr[PTR_W-1:0]] <= alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Writes to x0 consume their source but never assert the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_w_en       <= 1'b0;
            rf_write_rg   <= '0;
            rf_write_data <= '0;
            ld_err        <= 1'b0;
            wb_count      <= '0;
        end else begin
            rf_w_en  <= (sel != SEL_NONE) && (sel_rd != 5'd0);
            ld_err   <= ld_valid && ld_illegal;
            wb_count <= wb_count + 16'(((sel != SEL_NONE) && (sel_rd != 5'd0)) ? 1 : 0);
            if (sel != SEL_NONE) begin
                rf_write_rg   <= sel_rd;
                rf_write_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_wb_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_word;
    logic        rf_w_en;
    logic [4:0]  rf_write_rg;
    logic [31:0] rf_write_data;
    logic        ld_err;
    logic        busy;
    logic [15:0] wb_count;

    wb_stage #(.XLEN(32), .ALU_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
        .ld_addr_lo(ld_addr_lo), .ld_word(ld_word),
        .rf_w_en(rf_w_en), .rf_write_rg(rf_write_rg), .rf_write_data(rf_write_data),
        .ld_err(ld_err), .busy(busy), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } alu_entry_t;

    alu_entry_t  q[$];
    logic        e_wen;
    logic [4:0]  e_rg;
    logic [31:0] e_data;
    logic        e_err;
    logic [15:0] e_cnt;
    bit          fired;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load result computed from the ISA definition with plain arithmetic.
    function automatic logic [31:0] load_model(input logic [2:0] f, input logic [1:0] a,
                                               input logic [31:0] w, output bit err);
        int unsigned b;
        int unsigned h;
        b   = (w >> (8 * a)) & 32'hFF;
        h   = (w >> (16 * (a / 2))) & 32'hFFFF;
        err = 1'b0;
        case (f)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b101:  return h;
            3'b010:  return w;
            default: begin err = 1'b1; return 32'd0; end
        endcase
    endfunction

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addr_lo = '0; ld_word = '0;
    endtask

    // One clock cycle with inputs already driven: check combinational outputs,
    // advance the model, then check registered outputs after the edge.
    task automatic cycle(input bit do_check);
        alu_entry_t ent;
        bit         have;
        bit         bypass;
        bit         err;
        logic [4:0] rd;
        logic [31:0] data;
        bit         exp_ready;
        #1;
        exp_ready = !rst && (q.size() < DEPTH);
        if (do_check) begin
            check("alu_ready", {31'd0, alu_ready}, {31'd0, exp_ready});
            check("busy", {31'd0, busy}, {31'd0, q.size() != 0});
        end
        fired = alu_valid && exp_ready;
        if (rst) begin
            q.delete();
            e_wen = 0; e_rg = 0; e_data = 0; e_err = 0; e_cnt = 0;
        end else begin
            have = 0; bypass = 0; err = 0; rd = 0; data = 0;
            if (ld_valid) begin
                have = 1; rd = ld_rd;
                data = load_model(ld_funct3, ld_addr_lo, ld_word, err);
            end else if (q.size() != 0) begin
                ent = q.pop_front();
                have = 1; rd = ent.rd; data = ent.data;
            end else if (fired) begin
                have = 1; bypass = 1; rd = alu_rd; data = alu_data;
            end
            if (fired && !bypass) q.push_back('{rd: alu_rd, data: alu_data});
            e_err = ld_valid && err;
            e_wen = have && (rd != 0);
            if (have) begin e_rg = rd; e_data = data; end
            if (e_wen) e_cnt = e_cnt + 16'd1;
        end
        @(posedge clk);
        #1;
        if (do_check) begin
            check("rf_w_en", {31'd0, rf_w_en}, {31'd0, e_wen});
            if (e_wen) begin
                check("rf_write_rg", {27'd0, rf_write_rg}, {27'd0, e_rg});
                check("rf_write_data", rf_write_data, e_data);
            end
            check("ld_err", {31'd0, ld_err}, {31'd0, e_err});
            check("wb_count", {16'd0, wb_count}, {16'd0, e_cnt});
        end
    endtask

    initial begin
        int guard;
        idle();
        rst = 1'b1;
        cycle(1);
        cycle(1);
        check("reset_wb_count", {16'd0, wb_count}, 32'd0);
        check("reset_rf_w_en", {31'd0, rf_w_en}, 32'd0);
        rst = 1'b0;

        // Single ALU result bypasses straight to the write port.
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        cycle(1);
        idle();
        check("bypass_rg", {27'd0, rf_write_rg}, 32'd5);
        check("bypass_data", rf_write_data, 32'h1234);
        check("bypass_busy", {31'd0, busy}, 32'd0);
        check("bypass_count", {16'd0, wb_count}, 32'd1);

        // Load extraction cases.
        ld_valid = 1; ld_rd = 7; ld_funct3 = 3'b000; ld_addr_lo = 3; ld_word = 32'h80FF_0000;
        cycle(1);
        check("lb_data", rf_write_data, 32'hFFFF_FF80);
        ld_funct3 = 3'b100;
        cycle(1);
        check("lbu_data", rf_write_data, 32'h0000_0080);
        ld_funct3 = 3'b001; ld_addr_lo = 2;
        cycle(1);
        check("lh_data", rf_write_data, 32'hFFFF_80FF);
        idle();

        // Loads hold off ALU results; FIFO fills and drains in order.
        ld_valid = 1; ld_rd = 9; ld_funct3 = 3'b010; ld_word = 32'hCAFE_0001;
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        cycle(1);
        alu_rd = 2; alu_data = 32'h22;
        cycle(1);
        alu_rd = 3; alu_data = 32'h33;
        cycle(1);
        check("full_ready", {31'd0, alu_ready}, 32'd0);
        ld_valid = 0;
        cycle(1);
        check("drain_rd1", {27'd0, rf_write_rg}, 32'd1);
        cycle(1);
        check("drain_rd2", {27'd0, rf_write_rg}, 32'd2);
        check("rd3_accepted", {31'd0, fired}, 32'd1);
        idle();
        cycle(1);
        check("drain_rd3", {27'd0, rf_write_rg}, 32'd3);

        // x0 destination is consumed without a write.
        alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
        cycle(1);
        idle();
        check("x0_handshake", {31'd0, fired}, 32'd1);
        check("x0_no_write", {31'd0, rf_w_en}, 32'd0);

        // Illegal funct3 writes zero and flags an error.
        ld_valid = 1; ld_rd = 4; ld_funct3 = 3'b011; ld_word = 32'hFFFF_FFFF;
        cycle(1);
        idle();
        check("illegal_err", {31'd0, ld_err}, 32'd1);
        check("illegal_data", rf_write_data, 32'd0);
        cycle(1);
        check("err_one_pulse", {31'd0, ld_err}, 32'd0);

        // Reset with two buffered entries discards them.
        ld_valid = 1; ld_rd = 10; ld_funct3 = 3'b010; ld_word = 32'h5;
        alu_valid = 1; alu_rd = 11; alu_data = 32'hA;
        cycle(1);
        alu_rd = 12;
        cycle(1);
        idle();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1;
        cycle(1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_w_en", {31'd0, rf_w_en}, 32'd0);
        alu_valid = 1; alu_rd = 13;
        cycle(1);
        check("rst_ready", {31'd0, alu_ready}, 32'd0);
        rst = 0;
        idle();
        cycle(1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            ld_valid   = ($urandom_range(0, 9) < 3);
            ld_rd      = 5'($urandom);
            ld_funct3  = 3'($urandom);
            ld_addr_lo = 2'($urandom);
            ld_word    = $urandom;
            if (!alu_valid || fired) begin
                alu_valid = ($urandom_range(0, 9) < 6);
                alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
                alu_data  = $urandom;
            end
            cycle(1);
        end
        idle();
        guard = 0;
        while (q.size() != 0 && guard < 10) begin
            cycle(1);
            guard++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);

        // wb_count wrap-around.
        rst = 1;
        cycle(1);
        rst = 0;
        alu_valid = 1; alu_rd = 1; alu_data = 32'h77;
        for (int i = 0; i < 65535; i++) cycle(0);
        check("count_ffff", {16'd0, wb_count}, 32'h0000_FFFF);
        cycle(1);
        check("count_wrap", {16'd0, wb_count}, 32'd0);
        idle();
        cycle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
